// File: rtl/tag_ctrl_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped cache tag controller.
package tag_ctrl_pkg;

    localparam int unsigned TAG_W       = 22;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned OFF_W       = 4;
    localparam int unsigned ADDR_W      = TAG_W + IDX_W + OFF_W;
    localparam int unsigned NUM_ENTRIES = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CMP   = 3'd3,
        S_RESP  = 3'd4
    } tag_state_e;

    // Request latched on acceptance of a fill or lookup
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } tag_req_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

endpackage

// File: rtl/tag_ctrl_if.sv
// Request/response handshakes plus tag SRAM pins of the tag controller.
interface tag_ctrl_if;
    import tag_ctrl_pkg::*;

    logic              lk_valid;
    logic              lk_ready;
    logic [ADDR_W-1:0] lk_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic              fill_valid;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_done;
    logic              inv_valid;
    logic              inv_ready;
    logic [IDX_W-1:0]  inv_index;
    logic              flush;
    logic              tag_cs;
    logic              tag_oe;
    logic              tag_web;
    logic [IDX_W-1:0]  tag_a;
    logic [TAG_W-1:0]  tag_di;
    logic [TAG_W-1:0]  tag_do;

    modport slave (
        input  lk_valid, lk_addr, resp_ready, fill_valid, fill_addr,
               inv_valid, inv_index, flush, tag_do,
        output lk_ready, resp_valid, resp_hit, fill_ready, fill_done,
               inv_ready, tag_cs, tag_oe, tag_web, tag_a, tag_di
    );

    modport master (
        output lk_valid, lk_addr, resp_ready, fill_valid, fill_addr,
               inv_valid, inv_index, flush, tag_do,
        input  lk_ready, resp_valid, resp_hit, fill_ready, fill_done,
               inv_ready, tag_cs, tag_oe, tag_web, tag_a, tag_di
    );

endinterface

// File: rtl/tag_valid_bits.sv
// Per-entry valid flops: set one, clear one, clear all (clear-all dominates), combinational read.
module tag_valid_bits
    import tag_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic             i_clr,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic             i_clr_all,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid_c
);

    logic [NUM_ENTRIES-1:0] r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clr_all) begin
            r_valid <= '0;
        end else begin
            if (i_set) r_valid[i_set_idx] <= 1'b1;
            if (i_clr) r_valid[i_clr_idx] <= 1'b0;
        end
    end

    assign o_rd_valid_c = r_valid[i_rd_idx];

endmodule

// File: rtl/tag_ctrl.sv
// Tag SRAM sequencer for a direct-mapped cache: lookup, fill, invalidate and flush, one at a time.
module tag_ctrl
    import tag_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    tag_ctrl_if.slave  bus
);

    tag_state_e r_state, w_state_nxt;
    tag_req_t   r_req, w_req_nxt;

    logic r_resp_valid, w_resp_valid_nxt;
    logic r_resp_hit,   w_resp_hit_nxt;
    logic r_fill_done,  w_fill_done_nxt;
    logic r_cs,         w_cs_nxt;
    logic r_oe,         w_oe_nxt;
    logic r_web,        w_web_nxt;

    logic w_lk_ready, w_fill_ready, w_inv_ready;
    logic w_set, w_clr_one, w_rd_valid;
    logic w_unused_off;

    assign w_unused_off = ^{bus.lk_addr[OFF_W-1:0], bus.fill_addr[OFF_W-1:0]};

    tag_valid_bits u_valid (
        .clk          (clk),
        .rst          (rst),
        .i_set        (w_set),
        .i_set_idx    (r_req.idx),
        .i_clr        (w_clr_one),
        .i_clr_idx    (bus.inv_index),
        .i_clr_all    (bus.flush),
        .i_rd_idx     (r_req.idx),
        .o_rd_valid_c (w_rd_valid)
    );

    // State, latched request and all Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_fill_done  <= 1'b0;
            r_cs         <= 1'b0;
            r_oe         <= 1'b0;
            r_web        <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_hit   <= w_resp_hit_nxt;
            r_fill_done  <= w_fill_done_nxt;
            r_cs         <= w_cs_nxt;
            r_oe         <= w_oe_nxt;
            r_web        <= w_web_nxt;
        end
    end

    // Next state, arbitration in IDLE (flush > fill > inv > lookup), valid-bit updates
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_resp_hit_nxt = r_resp_hit;
        w_lk_ready     = 1'b0;
        w_fill_ready   = 1'b0;
        w_inv_ready    = 1'b0;
        w_set          = 1'b0;
        w_clr_one      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!bus.flush) begin
                    if (bus.fill_valid) begin
                        w_fill_ready = 1'b1;
                        w_req_nxt    = '{tag: get_tag(bus.fill_addr), idx: get_idx(bus.fill_addr)};
                        w_state_nxt  = S_WRITE;
                    end else if (bus.inv_valid) begin
                        w_inv_ready = 1'b1;
                        w_clr_one   = 1'b1;
                    end else begin
                        w_lk_ready = 1'b1;
                        if (bus.lk_valid) begin
                            w_req_nxt   = '{tag: get_tag(bus.lk_addr), idx: get_idx(bus.lk_addr)};
                            w_state_nxt = S_READ;
                        end
                    end
                end
            end
            S_WRITE: begin
                w_set       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                w_state_nxt = S_CMP;
            end
            S_CMP: begin
                // A flush arriving with the read data still forces a miss
                w_resp_hit_nxt = w_rd_valid & (bus.tag_do == r_req.tag) & ~bus.flush;
                w_state_nxt    = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_resp_valid_nxt = (w_state_nxt == S_RESP);
        w_fill_done_nxt  = (w_state_nxt == S_WRITE);
        w_cs_nxt         = (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ);
        w_oe_nxt         = (w_state_nxt == S_READ);
        w_web_nxt        = (w_state_nxt != S_WRITE);
    end

    assign bus.lk_ready   = w_lk_ready;
    assign bus.fill_ready = w_fill_ready;
    assign bus.inv_ready  = w_inv_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_hit   = r_resp_hit;
    assign bus.fill_done  = r_fill_done;
    assign bus.tag_cs     = r_cs;
    assign bus.tag_oe     = r_oe;
    assign bus.tag_web    = r_web;
    assign bus.tag_a      = r_req.idx;
    assign bus.tag_di     = r_req.tag;

endmodule

// File: tb/tb_tag_ctrl.sv
// Directed plus randomized bench for tag_ctrl with a behavioural SRAM and a cache-state reference model.
module tb_tag_ctrl;
    import tag_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    tag_ctrl_if bus();

    tag_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural tag SRAM: write on cs&~web, read data the cycle after cs&oe
    logic [TAG_W-1:0] sram [NUM_ENTRIES];
    logic [TAG_W-1:0] sram_do;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sram    <= '{default: '0};
            sram_do <= '0;
        end else begin
            if (bus.tag_cs && !bus.tag_web) sram[bus.tag_a] <= bus.tag_di;
            if (bus.tag_cs && bus.tag_oe)   sram_do <= sram[bus.tag_a];
        end
    end

    assign bus.tag_do = sram_do;

    // Reference cache state
    bit               ref_valid [NUM_ENTRIES];
    logic [TAG_W-1:0] ref_tag   [NUM_ENTRIES];

    function automatic logic [TAG_W-1:0] m_tag(input logic [31:0] a);
        return TAG_W'(a / 1024);
    endfunction

    function automatic logic [IDX_W-1:0] m_idx(input logic [31:0] a);
        return IDX_W'((a / 16) % 64);
    endfunction

    function automatic logic [31:0] mk_addr(input int unsigned t, input int unsigned i, input int unsigned o);
        return (32'(t) << 10) | (32'(i) << 4) | 32'(o);
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return ref_valid[m_idx(a)] && (ref_tag[m_idx(a)] == m_tag(a));
    endfunction

    task automatic m_clear_all();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    endtask

    task automatic chk1(input string nm, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", nm, obs, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lk_valid   = 1'b0;
        bus.lk_addr    = '0;
        bus.resp_ready = 1'b0;
        bus.fill_valid = 1'b0;
        bus.fill_addr  = '0;
        bus.inv_valid  = 1'b0;
        bus.inv_index  = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] addr);
        logic exp_hit;
        exp_hit      = m_hit(addr);
        bus.lk_valid = 1'b1;
        bus.lk_addr  = addr;
        #1;
        chk1("lookup.lk_ready", bus.lk_ready, 1'b1);
        tick();
        bus.lk_valid = 1'b0;
        chk1("lookup.read_cs", bus.tag_cs, 1'b1);
        chk1("lookup.read_oe", bus.tag_oe, 1'b1);
        chk1("lookup.read_web", bus.tag_web, 1'b1);
        chkw("lookup.tag_a", 32'(bus.tag_a), 32'(m_idx(addr)));
        tick();
        chk1("lookup.cmp_resp_valid", bus.resp_valid, 1'b0);
        chk1("lookup.cmp_cs", bus.tag_cs, 1'b0);
        tick();
        chk1("lookup.resp_valid", bus.resp_valid, 1'b1);
        chk1("lookup.resp_hit", bus.resp_hit, exp_hit);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk1("lookup.resp_drop", bus.resp_valid, 1'b0);
    endtask

    task automatic do_fill(input logic [31:0] addr, input bit flush_in_write);
        bus.fill_valid = 1'b1;
        bus.fill_addr  = addr;
        #1;
        chk1("fill.fill_ready", bus.fill_ready, 1'b1);
        chk1("fill.lk_ready", bus.lk_ready, 1'b0);
        tick();
        bus.fill_valid = 1'b0;
        chk1("fill.cs", bus.tag_cs, 1'b1);
        chk1("fill.web", bus.tag_web, 1'b0);
        chk1("fill.oe", bus.tag_oe, 1'b0);
        chkw("fill.tag_a", 32'(bus.tag_a), 32'(m_idx(addr)));
        chkw("fill.tag_di", 32'(bus.tag_di), 32'(m_tag(addr)));
        chk1("fill.fill_done", bus.fill_done, 1'b1);
        ref_tag[m_idx(addr)]   = m_tag(addr);
        ref_valid[m_idx(addr)] = 1'b1;
        if (flush_in_write) begin
            bus.flush = 1'b1;
            m_clear_all();
        end
        tick();
        bus.flush = 1'b0;
        chk1("fill.done_drop", bus.fill_done, 1'b0);
        chk1("fill.web_idle", bus.tag_web, 1'b1);
    endtask

    task automatic do_inv(input logic [IDX_W-1:0] idx);
        bus.inv_valid = 1'b1;
        bus.inv_index = idx;
        #1;
        chk1("inv.inv_ready", bus.inv_ready, 1'b1);
        tick();
        bus.inv_valid = 1'b0;
        ref_valid[idx] = 1'b0;
        #1;
        chk1("inv.no_sram", bus.tag_cs, 1'b0);
        chk1("inv.back_idle", bus.lk_ready, 1'b1);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        #1;
        chk1("flush.lk_ready", bus.lk_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        m_clear_all();
    endtask

    initial begin
        int unsigned op, t, ix, o;
        logic [31:0] a;

        idle_inputs();
        m_clear_all();
        rst = 1'b1;
        tick();
        tick();
        chk1("reset.resp_valid", bus.resp_valid, 1'b0);
        chk1("reset.resp_hit", bus.resp_hit, 1'b0);
        chk1("reset.fill_done", bus.fill_done, 1'b0);
        chk1("reset.tag_cs", bus.tag_cs, 1'b0);
        chk1("reset.tag_oe", bus.tag_oe, 1'b0);
        chk1("reset.tag_web", bus.tag_web, 1'b1);
        chkw("reset.tag_a", 32'(bus.tag_a), 32'h0);
        chkw("reset.tag_di", 32'(bus.tag_di), 32'h0);
        rst = 1'b0;
        tick();
        chk1("reset.lk_ready", bus.lk_ready, 1'b1);

        // Cold miss, then fill and hit on a different offset in the same line
        do_lookup(32'h0000_1230);
        do_fill(32'h0000_1230, 1'b0);
        do_lookup(32'h0000_123C);

        // Invalidate then lookup misses
        do_inv(6'h23);
        do_lookup(32'h0000_1230);

        // Simultaneous fill/inv/lookup: fill first, inv next, lookup last
        do_fill(32'h0000_1230, 1'b0);
        bus.fill_valid = 1'b1;
        bus.fill_addr  = 32'h0000_5670;
        bus.inv_valid  = 1'b1;
        bus.inv_index  = 6'h23;
        bus.lk_valid   = 1'b1;
        bus.lk_addr    = 32'h0000_5670;
        #1;
        chk1("prio.fill_ready", bus.fill_ready, 1'b1);
        chk1("prio.inv_ready0", bus.inv_ready, 1'b0);
        chk1("prio.lk_ready0", bus.lk_ready, 1'b0);
        tick();
        bus.fill_valid = 1'b0;
        ref_tag[6'h27]   = 22'h15;
        ref_valid[6'h27] = 1'b1;
        chk1("prio.write_inv_ready", bus.inv_ready, 1'b0);
        chk1("prio.write_lk_ready", bus.lk_ready, 1'b0);
        chk1("prio.fill_done", bus.fill_done, 1'b1);
        tick();
        chk1("prio.inv_ready1", bus.inv_ready, 1'b1);
        chk1("prio.lk_ready1", bus.lk_ready, 1'b0);
        tick();
        bus.inv_valid = 1'b0;
        ref_valid[6'h23] = 1'b0;
        #1;
        chk1("prio.lk_ready2", bus.lk_ready, 1'b1);
        do_lookup(32'h0000_5670);
        do_lookup(32'h0000_1230);

        // Flush during CMP forces a miss, and the following lookup misses too
        do_fill(32'h0000_1230, 1'b0);
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 32'h0000_1230;
        #1;
        tick();
        bus.lk_valid = 1'b0;
        tick();
        bus.flush = 1'b1;
        m_clear_all();
        tick();
        bus.flush = 1'b0;
        chk1("flushcmp.resp_valid", bus.resp_valid, 1'b1);
        chk1("flushcmp.resp_hit", bus.resp_hit, 1'b0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        do_lookup(32'h0000_1230);
        do_lookup(32'h0000_5670);

        // Response held for 5 cycles with a pending lookup; flush in RESP leaves the hit intact
        do_fill(32'h0000_1230, 1'b0);
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 32'h0000_1230;
        #1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk1("hold.resp_valid", bus.resp_valid, 1'b1);
            chk1("hold.resp_hit", bus.resp_hit, 1'b1);
            chk1("hold.lk_ready", bus.lk_ready, 1'b0);
            bus.flush = (i == 2);
            tick();
        end
        m_clear_all();
        bus.lk_valid   = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk1("hold.resp_drop", bus.resp_valid, 1'b0);
        do_lookup(32'h0000_1230);

        // Flush during WRITE wins over the set
        do_fill(32'h0000_1230, 1'b1);
        do_lookup(32'h0000_1230);

        // Highest index is an ordinary entry
        do_fill(mk_addr(5, 63, 0), 1'b0);
        do_lookup(mk_addr(5, 63, 15));
        do_lookup(mk_addr(5, 0, 0));
        do_lookup(mk_addr(6, 63, 0));

        // Reset mid-lookup abandons it
        do_fill(mk_addr(1, 2, 0), 1'b0);
        bus.lk_valid = 1'b1;
        bus.lk_addr  = mk_addr(1, 2, 0);
        #1;
        tick();
        bus.lk_valid = 1'b0;
        tick();
        rst = 1'b1;
        m_clear_all();
        #1;
        chk1("midrst.resp_valid", bus.resp_valid, 1'b0);
        chk1("midrst.tag_cs", bus.tag_cs, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk1("midrst.no_resp", bus.resp_valid, 1'b0);
        chk1("midrst.lk_ready", bus.lk_ready, 1'b1);
        do_lookup(mk_addr(1, 2, 0));

        // Randomized mix over a small tag/index pool so hits and aliasing occur
        for (int k = 0; k < 200; k++) begin
            op = $urandom_range(0, 9);
            t  = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       ix = 0;
                1:       ix = 1;
                2:       ix = 35;
                default: ix = 63;
            endcase
            o = $urandom_range(0, 15);
            a = mk_addr(t, ix, o);
            if (op <= 3)      do_lookup(a);
            else if (op <= 6) do_fill(a, ($urandom_range(0, 7) == 0));
            else if (op <= 8) do_inv(m_idx(a));
            else              do_flush();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
